// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks interrupt/exception/mret in MEM, kills the
// pipeline and plays a one-cycle CSR trap-write (TRAP) or return (RET).
module trap_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_addr,
    input  logic        exc_inst_misalign,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_ld_misalign,
    input  logic        exc_ld_fault,
    input  logic        exc_st_misalign,
    input  logic        exc_st_fault,
    input  logic        mem_mret,
    input  logic        irq,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_r,
    output logic        kill,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        csr_w,
    output logic        exception_unit_flag,
    output logic        mret,
    output logic [31:0] mcause_w,
    output logic [31:0] mepc_w,
    output logic [31:0] mtval_w
);

    typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                   irq_s;
    logic                   irq_pend;
    logic                   exc_any;
    logic                   take_trap;
    logic                   take_ret;
    logic [31:0]            cause;
    logic [31:0]            tval;
    logic [31:0]            tvec_base;
    logic                   unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_sync <= '0;
        else     irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq};
    end
    assign irq_s = irq_sync[SYNC_STAGES-1];

    assign irq_pend = irq_s & mstatus[3] & mem_valid;
    assign exc_any  = mem_valid & (exc_inst_misalign | exc_illegal | exc_ebreak | exc_ecall |
                                   exc_ld_misalign | exc_ld_fault | exc_st_misalign | exc_st_fault);
    assign take_trap = (state == IDLE) & (irq_pend | exc_any);
    assign take_ret  = (state == IDLE) & ~take_trap & mem_valid & mem_mret;

    // Interrupt outranks every synchronous exception in the same cycle.
    always_comb begin
        cause = 32'd0;
        tval  = 32'd0;
        if (irq_pend) begin
            cause = 32'h8000_000B;
            tval  = 32'd0;
        end else if (exc_inst_misalign) begin
            cause = 32'd0;
            tval  = mem_addr;
        end else if (exc_illegal) begin
            cause = 32'd2;
            tval  = mem_inst;
        end else if (exc_ebreak) begin
            cause = 32'd3;
            tval  = mem_pc;
        end else if (exc_ecall) begin
            cause = 32'd11;
            tval  = 32'd0;
        end else if (exc_ld_misalign) begin
            cause = 32'd4;
            tval  = mem_addr;
        end else if (exc_ld_fault) begin
            cause = 32'd5;
            tval  = mem_addr;
        end else if (exc_st_misalign) begin
            cause = 32'd6;
            tval  = mem_addr;
        end else if (exc_st_fault) begin
            cause = 32'd7;
            tval  = mem_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            csr_w               <= 1'b0;
            exception_unit_flag <= 1'b0;
            mret                <= 1'b0;
            redirect            <= 1'b0;
            mcause_w            <= '0;
            mepc_w              <= '0;
            mtval_w             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        state               <= TRAP;
                        csr_w               <= 1'b1;
                        exception_unit_flag <= 1'b1;
                        redirect            <= 1'b1;
                        mcause_w            <= cause;
                        mepc_w              <= mem_pc;
                        mtval_w             <= tval;
                    end else if (take_ret) begin
                        state    <= RET;
                        csr_w    <= 1'b1;
                        mret     <= 1'b1;
                        redirect <= 1'b1;
                    end
                end
                default: begin
                    state               <= IDLE;
                    csr_w               <= 1'b0;
                    exception_unit_flag <= 1'b0;
                    mret                <= 1'b0;
                    redirect            <= 1'b0;
                    mcause_w            <= '0;
                    mepc_w              <= '0;
                    mtval_w             <= '0;
                end
            endcase
        end
    end

    assign kill = take_trap | take_ret | (state != IDLE);

    // Target uses the live mtvec/mepc_r so a CSR write landing just before is honoured.
    assign tvec_base = {mtvec[31:2], 2'b00};
    always_comb begin
        redirect_pc = 32'd0;
        if (state == TRAP) begin
            if (mtvec[1:0] == 2'b01 && mcause_w[31])
                redirect_pc = tvec_base + {25'd0, mcause_w[4:0], 2'b00};
            else
                redirect_pc = tvec_base;
        end else if (state == RET) begin
            redirect_pc = mepc_r;
        end
    end

    assign unused_bits = ^{mstatus[31:4], mstatus[2:0], mcause_w[30:5]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: inputs driven on negedge, outputs sampled mid-cycle.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc, mem_inst, mem_addr;
    logic        exc_inst_misalign, exc_illegal, exc_ebreak, exc_ecall;
    logic        exc_ld_misalign, exc_ld_fault, exc_st_misalign, exc_st_fault;
    logic        mem_mret, irq;
    logic [31:0] mstatus, mtvec, mepc_r;
    logic        kill, redirect, csr_w, exception_unit_flag, mret;
    logic [31:0] redirect_pc, mcause_w, mepc_w, mtval_w;

    int n_chk  = 0;
    int n_pass = 0;

    trap_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_addr(mem_addr),
        .exc_inst_misalign(exc_inst_misalign), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_ld_misalign(exc_ld_misalign), .exc_ld_fault(exc_ld_fault),
        .exc_st_misalign(exc_st_misalign), .exc_st_fault(exc_st_fault),
        .mem_mret(mem_mret), .irq(irq),
        .mstatus(mstatus), .mtvec(mtvec), .mepc_r(mepc_r),
        .kill(kill), .redirect(redirect), .redirect_pc(redirect_pc),
        .csr_w(csr_w), .exception_unit_flag(exception_unit_flag), .mret(mret),
        .mcause_w(mcause_w), .mepc_w(mepc_w), .mtval_w(mtval_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    task automatic clear_inst();
        mem_valid = 0; mem_pc = 0; mem_inst = 0; mem_addr = 0;
        exc_inst_misalign = 0; exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0;
        exc_ld_misalign = 0; exc_ld_fault = 0; exc_st_misalign = 0; exc_st_fault = 0;
        mem_mret = 0;
    endtask

    // Advance to the next posedge and settle just after it.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_csr_w"}, {31'd0, csr_w}, 32'd0);
        chk({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
        chk({tag, "_mcause"}, mcause_w, 32'd0);
    endtask

    // One exception detection cycle followed by its TRAP cycle.
    task automatic exc_case(input string tag, input logic [31:0] exp_cause, input logic [31:0] exp_tval,
                            input logic [31:0] exp_epc);
        #1;
        chk({tag, "_kill"}, {31'd0, kill}, 32'd1);
        step();
        clear_inst();
        #1;
        chk({tag, "_csr_w"}, {31'd0, csr_w}, 32'd1);
        chk({tag, "_excflag"}, {31'd0, exception_unit_flag}, 32'd1);
        chk({tag, "_mcause"}, mcause_w, exp_cause);
        chk({tag, "_mepc"}, mepc_w, exp_epc);
        chk({tag, "_mtval"}, mtval_w, exp_tval);
        step();
        chk({tag, "_back_idle"}, {31'd0, csr_w}, 32'd0);
        to_negedge();
    endtask

    initial begin
        rst = 1; irq = 0; mstatus = 0; mtvec = 32'h200; mepc_r = 0;
        clear_inst();
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_kill", {31'd0, kill}, 32'd0);
        to_negedge();
        rst = 0;
        to_negedge();

        // Illegal instruction
        mem_valid = 1; mem_pc = 32'h100; exc_illegal = 1; mem_inst = 32'hFFFF_FFFF;
        #1;
        chk("ill_kill", {31'd0, kill}, 32'd1);
        chk("ill_no_early_w", {31'd0, csr_w}, 32'd0);
        step();
        clear_inst();
        #1;
        chk("ill_csr_w", {31'd0, csr_w}, 32'd1);
        chk("ill_excflag", {31'd0, exception_unit_flag}, 32'd1);
        chk("ill_redirect", {31'd0, redirect}, 32'd1);
        chk("ill_kill_trap", {31'd0, kill}, 32'd1);
        chk("ill_mcause", mcause_w, 32'd2);
        chk("ill_mepc", mepc_w, 32'h100);
        chk("ill_mtval", mtval_w, 32'hFFFF_FFFF);
        chk("ill_rpc", redirect_pc, 32'h200);
        step();
        chk_quiet("ill_after");
        to_negedge();

        // Priority cases
        mem_valid = 1; mem_pc = 32'h40; mem_addr = 32'h999; exc_ecall = 1; exc_ld_fault = 1;
        exc_case("ecall_ldf", 32'd11, 32'd0, 32'h40);
        mem_valid = 1; mem_pc = 32'h44; mem_addr = 32'hABC; exc_ld_fault = 1;
        exc_case("ldf", 32'd5, 32'hABC, 32'h44);
        mem_valid = 1; mem_pc = 32'h48; mem_addr = 32'h13; mem_inst = 32'h55;
        exc_inst_misalign = 1; exc_illegal = 1; exc_st_fault = 1;
        exc_case("imis", 32'd0, 32'h13, 32'h48);
        mem_valid = 1; mem_pc = 32'h4C; mem_addr = 32'h77; exc_ebreak = 1; exc_st_misalign = 1;
        exc_case("ebreak", 32'd3, 32'h4C, 32'h4C);

        // mem_valid low: flags ignored
        exc_illegal = 1; mem_mret = 1; mem_pc = 32'h60;
        #1;
        chk("nv_kill", {31'd0, kill}, 32'd0);
        step();
        chk("nv_csr_w", {31'd0, csr_w}, 32'd0);
        to_negedge();
        clear_inst();

        // mret
        mem_valid = 1; mem_mret = 1; mepc_r = 32'h1234;
        #1;
        chk("mret_kill", {31'd0, kill}, 32'd1);
        step();
        clear_inst();
        #1;
        chk("mret_csr_w", {31'd0, csr_w}, 32'd1);
        chk("mret_mret", {31'd0, mret}, 32'd1);
        chk("mret_excflag", {31'd0, exception_unit_flag}, 32'd0);
        chk("mret_redirect", {31'd0, redirect}, 32'd1);
        chk("mret_rpc", redirect_pc, 32'h1234);
        chk("mret_mcause", mcause_w, 32'd0);
        step();
        chk("mret_after", {31'd0, mret}, 32'd0);
        to_negedge();

        // Vectored interrupt with 2-stage sync
        mtvec = 32'h301; mstatus = 32'h88; mem_valid = 1; mem_pc = 32'h700; irq = 1;
        #1;
        chk("irq_sync0", {31'd0, kill}, 32'd0);
        step();
        chk("irq_sync1", {31'd0, kill}, 32'd0);
        step();
        chk("irq_pend_kill", {31'd0, kill}, 32'd1);
        step();
        mstatus = 32'h80;
        #1;
        chk("irq_mcause", mcause_w, 32'h8000_000B);
        chk("irq_mepc", mepc_w, 32'h700);
        chk("irq_mtval", mtval_w, 32'd0);
        chk("irq_rpc", redirect_pc, 32'h32C);
        step();
        chk("irq_mie0_kill", {31'd0, kill}, 32'd0);
        step();
        chk("irq_mie0_csr_w", {31'd0, csr_w}, 32'd0);
        to_negedge();

        // Interrupt beats exception in the same cycle (irq_s already high)
        mstatus = 32'h88; mtvec = 32'h200; mem_pc = 32'h500; exc_illegal = 1; mem_inst = 32'h1;
        #1;
        chk("ivx_kill", {31'd0, kill}, 32'd1);
        step();
        clear_inst(); irq = 0; mstatus = 0;
        #1;
        chk("ivx_mcause", mcause_w, 32'h8000_000B);
        chk("ivx_mepc", mepc_w, 32'h500);
        chk("ivx_mtval", mtval_w, 32'd0);
        chk("ivx_rpc", redirect_pc, 32'h200);
        repeat (3) step();
        to_negedge();

        // Async reset during TRAP
        mem_valid = 1; mem_pc = 32'h80; exc_ecall = 1;
        step();
        clear_inst();
        #1;
        chk("rst_in_trap", {31'd0, csr_w}, 32'd1);
        #1 rst = 1;
        #1;
        chk_quiet("rst_drop");
        chk("rst_drop_kill", {31'd0, kill}, 32'd0);
        chk("rst_drop_excflag", {31'd0, exception_unit_flag}, 32'd0);
        to_negedge();
        rst = 0;
        step();
        chk_quiet("rst_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h, want 0x%08h", n_chk, 0);
        $fatal(1);
    end
endmodule
